riscv_test_monitor: RTL and testbench

- Synthesizable pass/fail/timeout monitor that sits directly downstream of Core and consumes its retire stream plus the gp register (x3).
- Replaces ad-hoc bench polling of pc and gp for the rv32ui riscv-tests suite.
- Produces a sticky verdict, the failing test number, and cycle and retire counts.
- Benches only read its outputs and write result/*.txt.

---
 rtl/riscv_test_monitor_pkg.sv | 16 +
 rtl/riscv_test_monitor_if.sv | 27 ++
 rtl/riscv_test_monitor_sat_counter.sv | 22 ++
 rtl/riscv_test_monitor.sv | 106 ++++++++++
 tb/tb_riscv_test_monitor.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_test_monitor_pkg.sv
// Shared types and constants for the riscv-tests pass/fail/timeout monitor.
package riscv_test_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4,
    HANG    = 3'd5
  } status_e;

  localparam logic [31:0] DEFAULT_PASS_PC = 32'h0000_0044;
  localparam int unsigned GP_REG_IDX      = 3;

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Retire stream from the core into the monitor, plus the monitor's verdict outputs.
interface riscv_test_monitor_if #(
  parameter int unsigned CNT_W = 32
);
  import riscv_test_pkg::*;

  logic             start;
  logic             retire_valid;
  logic [31:0]      retire_pc;
  logic [31:0]      gp_value;
  status_e          status;
  logic             done;
  logic [30:0]      fail_testnum;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output start, retire_valid, retire_pc, gp_value,
    input  status, done, fail_testnum, cycle_count, retire_count
  );

  modport slave (
    input  start, retire_valid, retire_pc, gp_value,
    output status, done, fail_testnum, cycle_count, retire_count
  );

endinterface

// File: rtl/riscv_test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Watches the core retire stream and gp (x3) to produce a sticky riscv-tests verdict.
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter logic [31:0] PASS_PC        = DEFAULT_PASS_PC,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned HANG_LIMIT     = 16,
  parameter int unsigned CNT_W          = 32
) (
  input logic                  clk,
  input logic                  rst,
  riscv_test_monitor_if.slave  mon
);

  localparam int unsigned HW = $clog2(HANG_LIMIT + 1);
  localparam logic [CNT_W:0]  TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);
  localparam logic [HW-1:0]   HANG_LIM    = HW'(HANG_LIMIT);

  status_e          state;
  logic             done;
  logic [30:0]      fail_testnum;
  logic [31:0]      last_pc;
  logic [HW-1:0]    same_cnt;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  logic in_run;
  logic pass_retire;
  logic same_pc;
  logic hang_hit;
  logic timeout_hit;

  always_comb begin
    in_run      = (state == RUN);
    pass_retire = mon.retire_valid && (mon.retire_pc == PASS_PC);
    same_pc     = mon.retire_valid && (mon.retire_pc == last_pc);
    hang_hit    = same_pc && ((same_cnt + HW'(1)) == HANG_LIM);
    // Widened by one bit so a saturated counter cannot wrap into a false match.
    timeout_hit = (({1'b0, cycle_count} + (CNT_W+1)'(1)) == TIMEOUT_LIM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      done         <= 1'b0;
      fail_testnum <= '0;
      last_pc      <= '0;
      same_cnt     <= '0;
    end else if (mon.start) begin
      state        <= RUN;
      done         <= 1'b0;
      fail_testnum <= '0;
      same_cnt     <= '0;
    end else if (in_run) begin
      if (pass_retire) begin
        done <= 1'b1;
        if (mon.gp_value == 32'd1) begin
          state <= PASS;
        end else begin
          state        <= FAIL;
          fail_testnum <= mon.gp_value[31:1];
        end
      end else begin
        // PASS_PC retires end the test above, so they never reach the tracker.
        if (mon.retire_valid) begin
          if (same_pc) begin
            same_cnt <= same_cnt + HW'(1);
          end else begin
            last_pc  <= mon.retire_pc;
            same_cnt <= HW'(1);
          end
        end
        if (hang_hit) begin
          state <= HANG;
          done  <= 1'b1;
        end else if (timeout_hit) begin
          state <= TIMEOUT;
          done  <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (mon.start),
    .enable (in_run),
    .count  (cycle_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (mon.start),
    .enable (in_run && mon.retire_valid),
    .count  (retire_count)
  );

  assign mon.status       = state;
  assign mon.done         = done;
  assign mon.fail_testnum = fail_testnum;
  assign mon.cycle_count  = cycle_count;
  assign mon.retire_count = retire_count;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor with a queue-based expectation scoreboard.
module tb_riscv_test_monitor;
  import riscv_test_pkg::*;

  localparam int unsigned F_STATUS = 0;
  localparam int unsigned F_DONE   = 1;
  localparam int unsigned F_FAILN  = 2;
  localparam int unsigned F_CYCLE  = 3;
  localparam int unsigned F_RETIRE = 4;

  typedef struct {
    string       tag;
    int unsigned field;
    logic [31:0] value;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   compared;
  int   mismatched;

  riscv_test_monitor_if #(.CNT_W(32)) mon ();

  riscv_test_monitor #(
    .PASS_PC        (32'h0000_0044),
    .TIMEOUT_CYCLES (20),
    .HANG_LIMIT     (4),
    .CNT_W          (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int unsigned f);
    case (f)
      F_STATUS: observe = 32'(mon.status);
      F_DONE:   observe = 32'(mon.done);
      F_FAILN:  observe = 32'(mon.fail_testnum);
      F_CYCLE:  observe = mon.cycle_count;
      default:  observe = mon.retire_count;
    endcase
  endfunction

  task automatic push(string tag, logic [2:0] st, logic dn, logic [30:0] fn,
                      logic [31:0] cc, logic [31:0] rc);
    sb.push_back('{{tag, ".status"}, F_STATUS, 32'(st)});
    sb.push_back('{{tag, ".done"},   F_DONE,   32'(dn)});
    sb.push_back('{{tag, ".failnum"}, F_FAILN, 32'(fn)});
    sb.push_back('{{tag, ".cycles"}, F_CYCLE,  cc});
    sb.push_back('{{tag, ".retires"}, F_RETIRE, rc});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.field);
      compared++;
      assert (obs === e.value) else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.value);
      end
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic cyc(logic s, logic rv, logic [31:0] pc, logic [31:0] gp);
    mon.start        = s;
    mon.retire_valid = rv;
    mon.retire_pc    = pc;
    mon.gp_value     = gp;
    @(negedge clk);
    mon.start        = 1'b0;
    mon.retire_valid = 1'b0;
  endtask

  task automatic idle(int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    compared         = 0;
    mismatched       = 0;
    rst              = 1'b0;
    mon.start        = 1'b0;
    mon.retire_valid = 1'b0;
    mon.retire_pc    = '0;
    mon.gp_value     = '0;
    @(negedge clk);
    @(negedge clk);
    push("reset", IDLE, 1'b0, 31'd0, 32'd0, 32'd0);
    drain();
    rst = 1'b1;

    // Idle retires before any start are ignored.
    cyc(1'b0, 1'b1, 32'h44, 32'd1);
    push("pre_start", IDLE, 1'b0, 31'd0, 32'd0, 32'd0);
    drain();

    // Start cycle carries a retire that must be ignored.
    cyc(1'b1, 1'b1, 32'h44, 32'd1);
    push("start", RUN, 1'b0, 31'd0, 32'd0, 32'd0);
    drain();
    for (int unsigned i = 0; i <= 16; i++) cyc(1'b0, 1'b1, 32'(4 * i), 32'(i + 2));
    push("run17", RUN, 1'b0, 31'd0, 32'd17, 32'd17);
    drain();
    cyc(1'b0, 1'b1, 32'h44, 32'd1);
    push("pass", PASS, 1'b1, 31'd0, 32'd18, 32'd18);
    drain();
    idle(3);
    cyc(1'b0, 1'b1, 32'h44, 32'd7);
    push("pass_sticky", PASS, 1'b1, 31'd0, 32'd18, 32'd18);
    drain();

    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h44, 32'h0000_0007);
    push("fail7", FAIL, 1'b1, 31'd3, 32'd1, 32'd1);
    drain();
    for (int unsigned i = 0; i < 100; i++) cyc(1'b0, 1'(i % 2), 32'h44, 32'd1);
    push("fail_sticky", FAIL, 1'b1, 31'd3, 32'd1, 32'd1);
    drain();

    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h44, 32'h0);
    push("fail_gp0", FAIL, 1'b1, 31'd0, 32'd1, 32'd1);
    drain();
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h44, 32'hFFFF_FFFF);
    push("fail_gpmax", FAIL, 1'b1, 31'h7FFF_FFFF, 32'd1, 32'd1);
    drain();

    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    idle(19);
    push("pre_timeout", RUN, 1'b0, 31'd0, 32'd19, 32'd0);
    drain();
    idle(1);
    push("timeout", TIMEOUT, 1'b1, 31'd0, 32'd20, 32'd0);
    drain();
    idle(5);
    push("timeout_hold", TIMEOUT, 1'b1, 31'd0, 32'd20, 32'd0);
    drain();

    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h100, 32'h0);
    push("hang_pre", RUN, 1'b0, 31'd0, 32'd3, 32'd3);
    drain();
    cyc(1'b0, 1'b1, 32'h100, 32'h0);
    push("hang", HANG, 1'b1, 31'd0, 32'd4, 32'd4);
    drain();

    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h100, 32'h0);
    cyc(1'b0, 1'b1, 32'h100, 32'h0);
    cyc(1'b0, 1'b1, 32'h104, 32'h0);
    cyc(1'b0, 1'b1, 32'h100, 32'h0);
    push("no_hang", RUN, 1'b0, 31'd0, 32'd4, 32'd4);
    drain();

    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    idle(19);
    cyc(1'b0, 1'b1, 32'h44, 32'd1);
    push("pass_vs_timeout", PASS, 1'b1, 31'd0, 32'd20, 32'd1);
    drain();
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    push("restart", RUN, 1'b0, 31'd0, 32'd0, 32'd0);
    drain();

    cyc(1'b0, 1'b1, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h4, 32'h0);
    cyc(1'b0, 1'b1, 32'h8, 32'h0);
    push("mid_run", RUN, 1'b0, 31'd0, 32'd3, 32'd3);
    drain();
    #2 rst = 1'b0;
    #1;
    push("async_reset", IDLE, 1'b0, 31'd0, 32'd0, 32'd0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 32'h44, 32'd1);
    push("post_reset", IDLE, 1'b0, 31'd0, 32'd0, 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
